cmd_decoder: RTL and testbench

CMD_DECODER -- requirements
Module: cmd_decoder

---
 rtl/cmd_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_cmd_decoder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_decoder.sv
// Byte-stream command decoder: pops commands from an RX FIFO, drives a settings register file,
// trigger pulses, a readback word and a soft reset. Define CMD_TIMEOUT_EN to abort stalled payloads.
module cmd_decoder #(
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned NUM_TRIG  = 4,
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_rdata,
    input  logic                    rx_rempty,
    output logic                    rx_rinc,
    input  logic                    src_busy,
    output logic [NUM_TRIG-1:0]     trig,
    input  logic [NUM_TRIG-1:0]     trig_busy,
    output logic [NUM_REGS*8-1:0]   regs,
    output logic [15:0]             rd_data,
    output logic                    rd_avail,
    input  logic                    rd_accept,
    output logic                    soft_rst,
    output logic [7:0]              err_count
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CW = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;
    localparam logic [7:0]  CMD_SRST = 8'hFF;
    localparam logic [7:0]  CMD_WR   = 8'h40;
    localparam logic [7:0]  CMD_RD   = 8'h80;

    typedef enum logic [2:0] {
        IDLE, PAYLOAD, EXEC, TRIG_WAIT, TRIG_PULSE, RD_WAIT, SOFT_RST
    } state_t;

    state_t                 state_q, state_d;
    logic                   is_wr_q, is_wr_d;
    logic                   have_addr_q, have_addr_d;
    logic [7:0]             addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [5:0]             ch_q, ch_d;
    logic [7:0]             pulse_q, pulse_d;
    logic [NUM_TRIG-1:0]    trig_d;
    logic                   rinc_d;
    logic [15:0]            rd_data_d;
    logic                   rd_avail_d;
    logic                   soft_rst_d;
    logic                   err_inc;
    logic                   reg_we;
    logic                   reg_clr;
    logic                   pop;
    logic                   addr_ok;
    logic                   ch_ok;
    logic [AW-1:0]          addr_idx;
    logic [CW-1:0]          ch_idx;
    logic [7:0]             reg_q [NUM_REGS];

    // A pop needs a non-empty, idle source and no pop still in flight
    assign pop      = !rx_rempty && !src_busy && !rx_rinc &&
                      (state_q == IDLE || state_q == PAYLOAD);
    assign addr_ok  = 32'(addr_q) < NUM_REGS;
    assign ch_ok    = 32'(rx_rdata[5:0]) < NUM_TRIG;
    assign addr_idx = addr_q[AW-1:0];
    assign ch_idx   = ch_q[CW-1:0];

    for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_flat
        assign regs[8*k +: 8] = reg_q[k];
    end

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TMW = $clog2(TIMEOUT + 1);
    logic [TMW-1:0] tmo_q;
    logic           tmo_hit;
    assign tmo_hit = (tmo_q == TMW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || state_q != PAYLOAD || pop) tmo_q <= '0;
        else                                     tmo_q <= tmo_q + TMW'(1);
    end
`endif

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        have_addr_d = have_addr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ch_d        = ch_q;
        pulse_d     = pulse_q;
        trig_d      = trig;
        rinc_d      = pop;
        rd_data_d   = rd_data;
        rd_avail_d  = rd_avail;
        soft_rst_d  = 1'b0;
        err_inc     = 1'b0;
        reg_we      = 1'b0;
        reg_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    if (rx_rdata == CMD_SRST) begin
                        state_d = SOFT_RST;
                    end else if (rx_rdata[7:6] == 2'b00) begin
                        if (ch_ok) begin
                            ch_d    = rx_rdata[5:0];
                            state_d = TRIG_WAIT;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else if (rx_rdata == CMD_WR || rx_rdata == CMD_RD) begin
                        is_wr_d     = (rx_rdata == CMD_WR);
                        have_addr_d = 1'b0;
                        state_d     = PAYLOAD;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (pop) begin
                    if (!have_addr_q) begin
                        addr_d      = rx_rdata;
                        have_addr_d = 1'b1;
                        if (!is_wr_q) state_d = EXEC;
                    end else begin
                        wdata_d = rx_rdata;
                        state_d = EXEC;
                    end
                end
`ifdef CMD_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_inc = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            EXEC: begin
                state_d = IDLE;
                if (!addr_ok) begin
                    err_inc = 1'b1;
                end else if (is_wr_q) begin
                    reg_we = 1'b1;
                end else begin
                    rd_data_d  = {addr_q, reg_q[addr_idx]};
                    rd_avail_d = 1'b1;
                    state_d    = RD_WAIT;
                end
            end
            TRIG_WAIT: begin
                if (!trig_busy[ch_idx]) begin
                    trig_d  = NUM_TRIG'(1) << ch_idx;
                    pulse_d = 8'(PULSE_LEN - 1);
                    state_d = TRIG_PULSE;
                end
            end
            TRIG_PULSE: begin
                if (pulse_q == 8'd0) begin
                    trig_d  = '0;
                    state_d = IDLE;
                end else begin
                    pulse_d = pulse_q - 8'd1;
                end
            end
            RD_WAIT: begin
                if (rd_accept) begin
                    rd_avail_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            SOFT_RST: begin
                soft_rst_d = 1'b1;
                reg_clr    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            have_addr_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ch_q        <= '0;
            pulse_q     <= '0;
            trig        <= '0;
            rx_rinc     <= 1'b0;
            rd_data     <= '0;
            rd_avail    <= 1'b0;
            soft_rst    <= 1'b0;
            err_count   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            have_addr_q <= have_addr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ch_q        <= ch_d;
            pulse_q     <= pulse_d;
            trig        <= trig_d;
            rx_rinc     <= rinc_d;
            rd_data     <= rd_data_d;
            rd_avail    <= rd_avail_d;
            soft_rst    <= soft_rst_d;
            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (reg_clr) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
            end else if (reg_we) begin
                reg_q[addr_idx] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed self-checking bench for cmd_decoder; models the RX FIFO as a byte queue.
// Build with CMD_TIMEOUT_EN defined to exercise the payload timeout path.
module tb_cmd_decoder;

    localparam int unsigned TMO = 64;
    localparam int unsigned PL  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_rdata;
    logic        rx_rempty;
    logic        rx_rinc;
    logic        src_busy;
    logic [3:0]  trig;
    logic [3:0]  trig_busy;
    logic [31:0] regs;
    logic [15:0] rd_data;
    logic        rd_avail;
    logic        rd_accept;
    logic        soft_rst;
    logic [7:0]  err_count;

    int          checks = 0;
    int          fails  = 0;
    logic [7:0]  fifo [$];

    cmd_decoder #(.NUM_REGS(4), .NUM_TRIG(4), .PULSE_LEN(PL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdata(rx_rdata), .rx_rempty(rx_rempty),
        .rx_rinc(rx_rinc), .src_busy(src_busy), .trig(trig), .trig_busy(trig_busy),
        .regs(regs), .rd_data(rd_data), .rd_avail(rd_avail), .rd_accept(rd_accept),
        .soft_rst(soft_rst), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic upd();
        rx_rempty = (fifo.size() == 0);
        rx_rdata  = rx_rempty ? 8'h00 : fifo[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        upd();
    endtask

    // One clock: the FIFO pops on the edge where rx_rinc is high; returns at the next negedge
    task automatic cyc();
        bit do_pop;
        do_pop = rx_rinc;
        @(posedge clk);
        #1;
        if (do_pop && fifo.size() > 0) void'(fifo.pop_front());
        upd();
        @(negedge clk);
    endtask

    task automatic drain(output bit saw_trig);
        int k = 0;
        saw_trig = 1'b0;
        while ((fifo.size() != 0 || rx_rinc) && k < 3000) begin
            cyc();
            if (trig !== 4'h0) saw_trig = 1'b1;
            k++;
        end
        if (k >= 3000) begin
            checks++; fails++;
            $display("FAIL drain: fifo still holds %0d bytes, required 0", fifo.size());
        end
        repeat (6) begin
            cyc();
            if (trig !== 4'h0) saw_trig = 1'b1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        fifo.delete();
        upd();
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({regs, trig, rx_rinc, rd_avail, rd_data, soft_rst, err_count} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: regs=%h trig=%h rinc=%b avail=%b rd=%h srst=%b err=%h, required all 0",
                     regs, trig, rx_rinc, rd_avail, rd_data, soft_rst, err_count);
        end
    endtask

    task automatic test_write();
        int pops = 0;
        int k = 0;
        bit st;
        push(8'h40); push(8'h02); push(8'h5A);
        while (pops < 3 && k < 50) begin
            cyc();
            if (rx_rinc) pops++;
            k++;
        end
        checks++;
        if (pops != 3 || regs !== 32'h0) begin
            fails++;
            $display("FAIL write_before: pops=%0d regs=%h, required 3 pops and regs 0", pops, regs);
        end
        cyc();
        checks++;
        if (regs !== 32'h005A0000 || err_count !== 8'h00) begin
            fails++;
            $display("FAIL write_after: regs=%h err=%h, required 005a0000 and 00", regs, err_count);
        end
        drain(st);
    endtask

    task automatic test_read();
        int k = 0;
        int bad = 0;
        push(8'h80); push(8'h02);
        rd_accept = 1'b0;
        while (!rd_avail && k < 100) begin cyc(); k++; end
        for (int i = 0; i < 10; i++) begin
            if (rd_avail !== 1'b1 || rd_data !== 16'h025A) bad++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL read_hold: %0d bad cycles (last avail=%b data=%h), required avail 1 data 025a", bad, rd_avail, rd_data);
        end
        rd_accept = 1'b1;
        cyc();
        rd_accept = 1'b0;
        checks++;
        if (rd_avail !== 1'b0) begin
            fails++;
            $display("FAIL read_accept: rd_avail=%b, required 0", rd_avail);
        end
    endtask

    task automatic test_trigger();
        int busy_bad = 0;
        int high = 0;
        int other = 0;
        trig_busy = 4'b0010;
        push(8'h01);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (trig !== 4'h0) busy_bad++;
        end
        checks++;
        if (busy_bad != 0) begin
            fails++;
            $display("FAIL trig_busy: trig nonzero for %0d cycles while busy, required 0", busy_bad);
        end
        trig_busy = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (trig === 4'b0010) high++;
            else if (trig !== 4'b0000) other++;
        end
        checks++;
        if (high != int'(PL) || other != 0) begin
            fails++;
            $display("FAIL trig_pulse: high=%0d other=%0d, required %0d and 0", high, other, PL);
        end
    endtask

    task automatic test_errors();
        bit st;
        push(8'h40); push(8'h07); push(8'h11); push(8'h3F); push(8'h33);
        drain(st);
        checks++;
        if (regs !== 32'h005A0000 || st || err_count !== 8'd3) begin
            fails++;
            $display("FAIL err_basic: regs=%h trig_seen=%b err=%0d, required 005a0000, 0, 3", regs, st, err_count);
        end
        for (int i = 0; i < 256; i++) push(8'hC0);
        drain(st);
        checks++;
        if (err_count !== 8'hFF) begin
            fails++;
            $display("FAIL err_saturate: err=%h, required ff", err_count);
        end
    endtask

    task automatic test_timeout();
        bit st;
        apply_reset();
        push(8'h40); push(8'h01);
        drain(st);
`ifdef CMD_TIMEOUT_EN
        repeat (TMO + 10) cyc();
        checks++;
        if (err_count !== 8'd1 || regs !== 32'h0) begin
            fails++;
            $display("FAIL timeout_abort: err=%0d regs=%h, required 1 and 0", err_count, regs);
        end
        push(8'h77);
        drain(st);
        checks++;
        if (err_count !== 8'd2 || regs !== 32'h0) begin
            fails++;
            $display("FAIL timeout_idle: err=%0d regs=%h, required 2 and 0", err_count, regs);
        end
`else
        repeat (2 * TMO) cyc();
        checks++;
        if (err_count !== 8'd0 || regs !== 32'h0) begin
            fails++;
            $display("FAIL wait_forever: err=%0d regs=%h, required 0 and 0", err_count, regs);
        end
        push(8'h77);
        drain(st);
        checks++;
        if (regs !== 32'h00007700 || err_count !== 8'd0) begin
            fails++;
            $display("FAIL late_byte: regs=%h err=%0d, required 00007700 and 0", regs, err_count);
        end
`endif
    endtask

    task automatic test_soft_reset();
        bit st;
        int pulses = 0;
        apply_reset();
        push(8'h40); push(8'h00); push(8'h11);
        push(8'h40); push(8'h03); push(8'h22);
        push(8'hC1);
        drain(st);
        checks++;
        if (regs !== 32'h22000011 || err_count !== 8'd1) begin
            fails++;
            $display("FAIL srst_setup: regs=%h err=%0d, required 22000011 and 1", regs, err_count);
        end
        push(8'hFF);
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (soft_rst) pulses++;
        end
        checks++;
        if (pulses != 1 || regs !== 32'h0 || err_count !== 8'd1) begin
            fails++;
            $display("FAIL soft_reset: pulses=%0d regs=%h err=%0d, required 1, 0, 1", pulses, regs, err_count);
        end
    endtask

    task automatic test_reset_mid();
        bit st;
        push(8'h40); push(8'h01);
        drain(st);
        src_busy = 1'b1;
        push(8'h99);
        rst_n = 1'b0;
        repeat (2) cyc();
        checks++;
        if ({regs, trig, rx_rinc, rd_avail, rd_data, soft_rst, err_count} !== '0 || fifo.size() != 1) begin
            fails++;
            $display("FAIL reset_mid: regs=%h trig=%h rinc=%b err=%h fifo=%0d, required all 0 and 1 byte left",
                     regs, trig, rx_rinc, err_count, fifo.size());
        end
        rst_n    = 1'b1;
        src_busy = 1'b0;
        drain(st);
        checks++;
        if (regs !== 32'h0 || err_count !== 8'd1) begin
            fails++;
            $display("FAIL reset_abandon: regs=%h err=%0d, required 0 and 1", regs, err_count);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        src_busy  = 1'b0;
        trig_busy = 4'h0;
        rd_accept = 1'b0;
        upd();
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_trigger();
        test_errors();
        test_timeout();
        test_soft_reset();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
